// File: rtl/buffered_uart_tx_if.sv
// Native picorv32-style memory bus between the CPU (master) and a peripheral (slave).
interface buffered_uart_tx_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/buffered_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO; registers DATA/DIV/STAT in a 16-byte window.
module buffered_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] DEFAULT_DIV = 32'd104
) (
    input  logic                  clk,
    input  logic                  resetn,
    buffered_uart_tx_if.slave     bus,
    output logic                  uart_tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    tx_state_t        state;
    logic [31:0]      div_reg;
    logic [31:0]      div_eff;
    logic [31:0]      div_lat;
    logic [31:0]      bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shifter;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             fifo_full;
    logic             fifo_empty;

    logic             sel;
    logic [1:0]       reg_idx;
    logic             push_req;
    logic             go;
    logic             acc;
    logic             push;
    logic             pop;
    logic             cnt_end;
    logic [31:0]      stat;
    logic [31:0]      rd_val;
    logic             unused_addr;

    assign unused_addr = &{1'b0, bus.mem_addr[1:0]};

    assign sel        = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx    = bus.mem_addr[3:2];
    assign push_req   = (reg_idx == 2'd0) && bus.mem_wstrb[0];
    assign fifo_full  = (level == DEPTH_LVL);
    assign fifo_empty = (level == '0);
    // A data write into a full FIFO is held off until the transmitter frees a slot.
    assign go         = sel && !(push_req && fifo_full);
    assign acc        = go && !bus.mem_ready;
    assign push       = acc && push_req;

    assign div_eff = (div_reg == 32'd0) ? 32'd1 : div_reg;
    assign cnt_end = (bit_cnt == div_lat - 32'd1);
    assign pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && cnt_end));

    assign stat = {16'd0, 8'(level), 5'd0, fifo_empty, fifo_full, (state != IDLE)};

    always_comb begin
        rd_val = 32'd0;
        case (reg_idx)
            2'd1:    rd_val = div_reg;
            2'd2:    rd_val = stat;
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= 32'd0;
            div_reg       <= DEFAULT_DIV;
        end else begin
            bus.mem_ready <= go && !bus.mem_ready;
            bus.mem_rdata <= acc ? rd_val : 32'd0;
            if (acc && (reg_idx == 2'd1)) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.mem_wstrb[i]) div_reg[8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Bit period is latched at pop so a DIV write only affects the following frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            bit_cnt <= 32'd0;
            bit_idx <= 3'd0;
            div_lat <= 32'd1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shifter <= fifo_mem[rd_ptr];
                        div_lat <= div_eff;
                        bit_cnt <= 32'd0;
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt_end) begin
                        bit_cnt <= 32'd0;
                        bit_idx <= 3'd0;
                        uart_tx <= shifter[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (cnt_end) begin
                        bit_cnt <= 32'd0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shifter <= {1'b0, shifter[7:1]};
                            uart_tx <= shifter[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (cnt_end) begin
                        bit_cnt <= 32'd0;
                        if (pop) begin
                            shifter <= fifo_mem[rd_ptr];
                            div_lat <= div_eff;
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            state   <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffered_uart_tx.sv
// Bench for buffered_uart_tx: bus tasks drive the CPU side, a serial monitor decodes uart_tx
// cycle-exactly and each received frame is compared against a queue of expected bytes.
module tb_buffered_uart_tx;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam int          DEPTH = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic uart_tx;

    buffered_uart_tx_if bus();

    buffered_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(32'd104)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  byte_arr [256];
    int          div_arr  [256];
    int          push_cnt = 0;
    logic [31:0] cur_div = 32'd104;

    logic [7:0]  res_byte   [256];
    bit          res_bad    [256];
    bit          res_unexp  [256];
    int          res_start  [256];
    int          res_wr = 0;
    int          res_rd = 0;

    bit          mon_active = 1'b0;
    int          mon_cnt = 0;
    int          mon_d = 1;
    logic [9:0]  mon_bits = 10'h3FF;
    logic [7:0]  mon_rx = 8'h00;
    bit          mon_bad = 1'b0;
    int          cyc = 0;

    // Serial monitor: compares every cycle of a frame against the ideal 8N1 waveform.
    always @(negedge clk) begin
        int k;
        cyc++;
        if (!resetn) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && uart_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
                mon_bad = 1'b0;
                mon_rx = 8'h00;
                res_start[res_wr % 256] = cyc;
                if (res_wr < push_cnt) begin
                    mon_d = div_arr[res_wr % 256];
                    mon_bits = {1'b1, byte_arr[res_wr % 256], 1'b0};
                    res_unexp[res_wr % 256] = 1'b0;
                end else begin
                    mon_d = 1;
                    mon_bits = 10'h3FE;
                    res_unexp[res_wr % 256] = 1'b1;
                end
            end
            if (mon_active) begin
                k = mon_cnt / mon_d;
                if (uart_tx !== mon_bits[k]) mon_bad = 1'b1;
                if ((mon_cnt % mon_d) == (mon_d / 2) && k >= 1 && k <= 8) mon_rx[k-1] = uart_tx;
                mon_cnt++;
                if (mon_cnt == 10 * mon_d) begin
                    res_byte[res_wr % 256] = mon_rx;
                    res_bad[res_wr % 256] = mon_bad;
                    res_wr++;
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int waited);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (bus.mem_ready !== 1'b1 && waited < 500);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        if (bus.mem_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL write_ack addr=%h: no ready after %0d cycles", a, waited);
        end else if (a[31:4] == BASE[31:4]) begin
            if (a[3:2] == 2'd0 && s[0]) begin
                exp_q.push_back(d[7:0]);
                byte_arr[push_cnt % 256] = d[7:0];
                div_arr[push_cnt % 256] = (cur_div == 32'd0) ? 1 : int'(cur_div);
                push_cnt++;
            end else if (a[3:2] == 2'd1) begin
                for (int i = 0; i < 4; i++) if (s[i]) cur_div[8*i +: 8] = d[8*i +: 8];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        int w;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (bus.mem_ready !== 1'b1 && w < 500);
        d = bus.mem_rdata;
        bus.mem_valid = 1'b0;
        if (bus.mem_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL read_ack addr=%h: no ready after %0d cycles", a, w);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_frames(input int n, input string name);
        int w;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (res_rd >= res_wr && w < 400) begin
                @(posedge clk); #1;
                w++;
            end
            checks++;
            if (res_rd >= res_wr) begin
                errors++;
                $display("FAIL %s frame%0d: no frame within %0d cycles", name, i, w);
                return;
            end
            if (exp_q.size() == 0 || res_unexp[res_rd % 256]) begin
                errors++;
                $display("FAIL %s frame%0d: unexpected frame got=%h", name, i, res_byte[res_rd % 256]);
            end else begin
                e = exp_q.pop_front();
                if (res_byte[res_rd % 256] !== e || res_bad[res_rd % 256]) begin
                    errors++;
                    $display("FAIL %s frame%0d: got=%h timing_bad=%0d, expected %h with exact timing",
                             name, i, res_byte[res_rd % 256], res_bad[res_rd % 256], e);
                end
            end
            res_rd++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        resetn = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1 || bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: tx=%b ready=%b rdata=%h, expected 1/0/0", uart_tx, bus.mem_ready, bus.mem_rdata);
        end
        resetn = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr = BASE + 32'h8;
        @(posedge clk); #1;
        checks++;
        if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== 32'h4) begin
            errors++;
            $display("FAIL reset_stat: ready=%b rdata=%h, expected 1 and 00000004", bus.mem_ready, bus.mem_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_single_pulse: ready=%b, expected 0", bus.mem_ready);
        end
        bus.mem_valid = 1'b0;
        @(posedge clk); #1;
        bus_read(BASE + 32'h4, r);
        checks++;
        if (r !== 32'd104) begin
            errors++;
            $display("FAIL reset_div: got %0d, expected 104", r);
        end
    endtask

    task automatic test_registers();
        logic [31:0] r;
        int w;
        bit seen;
        bus.mem_valid = 1'b1;
        bus.mem_addr = BASE + 32'h10;
        bus.mem_wstrb = 4'h0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.mem_ready === 1'b1) seen = 1'b1;
        end
        bus.mem_valid = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL outside_window: ready=1, expected no ack");
        end
        @(posedge clk); #1;
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, w);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, w);
        bus_write(BASE + 32'h0, 32'h0000_1234, 4'b0010, w);
        bus_read(BASE + 32'h8, r);
        checks++;
        if (r !== 32'h4) begin
            errors++;
            $display("FAIL stat_ignored_writes: got %h, expected 00000004", r);
        end
        bus_read(BASE + 32'hC, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL reg_c_read: got %h, expected 00000000", r);
        end
        bus_read(BASE + 32'h0, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL data_read: got %h, expected 00000000", r);
        end
        bus_write(BASE + 32'h4, 32'h0000_1234, 4'hF, w);
        bus_write(BASE + 32'h4, 32'hAB00_0000, 4'b1000, w);
        bus_read(BASE + 32'h4, r);
        checks++;
        if (r !== 32'hAB00_1234) begin
            errors++;
            $display("FAIL div_byte_strobe: got %h, expected ab001234", r);
        end
    endtask

    task automatic test_frame_55();
        logic [31:0] r;
        int w;
        bus_write(BASE + 32'h4, 32'd4, 4'hF, w);
        bus_write(BASE + 32'h0, 32'h55, 4'h1, w);
        check_frames(1, "frame_55");
        bus_read(BASE + 32'h8, r);
        checks++;
        if (r !== 32'h4) begin
            errors++;
            $display("FAIL stat_after_frame: got %h, expected 00000004", r);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int gap;
        bus_write(BASE + 32'h4, 32'd8, 4'hF, w);
        bus_write(BASE + 32'h0, 32'hA5, 4'h1, w);
        bus_write(BASE + 32'h0, 32'h3C, 4'h1, w);
        check_frames(2, "back_to_back");
        gap = res_start[(res_rd - 1) % 256] - res_start[(res_rd - 2) % 256];
        checks++;
        if (gap != 80) begin
            errors++;
            $display("FAIL back_to_back_gap: start spacing %0d cycles, expected 80", gap);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] r;
        int w;
        bit all_fast;
        bus_write(BASE + 32'h4, 32'd16, 4'hF, w);
        all_fast = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            bus_write(BASE + 32'h0, 32'((i * 13 + 7) & 8'hFF), 4'h1, w);
            if (w != 1) all_fast = 1'b0;
        end
        checks++;
        if (!all_fast) begin
            errors++;
            $display("FAIL fifo_fill_ack: a write among the first %0d waited, expected immediate acks", DEPTH + 1);
        end
        bus_read(BASE + 32'h8, r);
        checks++;
        if (r !== 32'h0000_1003) begin
            errors++;
            $display("FAIL stat_full: got %h, expected 00001003", r);
        end
        bus_write(BASE + 32'h0, 32'hE1, 4'h1, w);
        checks++;
        if (w < 100 || w > 170) begin
            errors++;
            $display("FAIL fifo_stall: stalled %0d cycles, expected 100..170", w);
        end
        check_frames(DEPTH + 2, "fifo_full");
    endtask

    task automatic test_div_change();
        logic [31:0] r;
        int w;
        int gap;
        bus_write(BASE + 32'h4, 32'd8, 4'hF, w);
        bus_write(BASE + 32'h0, 32'hFF, 4'h1, w);
        repeat (30) @(posedge clk);
        #1;
        bus_write(BASE + 32'h4, 32'd2, 4'hF, w);
        bus_read(BASE + 32'h4, r);
        checks++;
        if (r !== 32'd2) begin
            errors++;
            $display("FAIL div_readback: got %0d, expected 2", r);
        end
        bus_write(BASE + 32'h0, 32'h0F, 4'h1, w);
        check_frames(2, "div_change");
        gap = res_start[(res_rd - 1) % 256] - res_start[(res_rd - 2) % 256];
        checks++;
        if (gap != 80) begin
            errors++;
            $display("FAIL div_change_frame1_len: %0d cycles, expected 80", gap);
        end
        bus_write(BASE + 32'h4, 32'd0, 4'hF, w);
        bus_write(BASE + 32'h0, 32'h81, 4'h1, w);
        check_frames(1, "div_zero");
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        int w;
        int frames_before;
        bus_write(BASE + 32'h4, 32'd8, 4'hF, w);
        bus_write(BASE + 32'h0, 32'h00, 4'h1, w);
        bus_write(BASE + 32'h0, 32'h00, 4'h1, w);
        bus_write(BASE + 32'h0, 32'h00, 4'h1, w);
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL midframe_low: tx=%b, expected 0 inside a data bit", uart_tx);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (uart_tx !== 1'b1 || bus.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: tx=%b ready=%b, expected 1/0", uart_tx, bus.mem_ready);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_q.delete();
        push_cnt = res_wr;
        cur_div = 32'd104;
        frames_before = res_wr;
        bus_read(BASE + 32'h8, r);
        checks++;
        if (r !== 32'h4) begin
            errors++;
            $display("FAIL reset_stat_after: got %h, expected 00000004", r);
        end
        bus_read(BASE + 32'h4, r);
        checks++;
        if (r !== 32'd104) begin
            errors++;
            $display("FAIL reset_div_after: got %0d, expected 104", r);
        end
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (res_wr != frames_before || uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_flush: %0d frames after reset, tx=%b, expected 0 frames and idle", res_wr - frames_before, uart_tx);
        end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_frame_55();
        test_back_to_back();
        test_fifo_full();
        test_div_change();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
